vc_allocator: RTL and testbench

- Router-wide virtual-channel allocation stage that serves every input_buffer instance.
- Collects VA-state requests (vc_request, out_port) from all input-port VCs and tracks which downstream VCs of each output port are free.
- Each cycle it grants at most one free downstream VC per output port and returns vc_valid / vc_new to the winning buffer.
- Downstream VCs are returned to the free pool when the neighbouring router reports them released.

---
 rtl/noc_params.sv | 19 +
 rtl/round_robin_arbiter.sv | 59 +++++
 rtl/vc_allocator.sv | 123 ++++++++++++
 tb/tb_vc_allocator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared router parameters: port count, VCs per port and the port encoding.
// Latency: none, this file only holds constants and types.
// Backpressure: none.
package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int VC_SIZE  = $clog2(VC_NUM);

  // Legal encodings stop at EAST; anything above it is a protocol error.
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: grant is combinational; the pointer moves on the edge when update_i is high.
// Backpressure: the caller masks requests it cannot serve; the pointer holds without update_i.
module round_robin_arbiter #(
  parameter int N  = 10,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  requests_i,
  input  logic          update_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;

  // Scan the requests starting at the pointer and wrapping at N; first hit wins.
  always_comb begin
    logic [PW:0] idx;
    grant_o = '0;
    win_idx = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && requests_i[idx[PW-1:0]]) begin
        grant_o[idx[PW-1:0]] = 1'b1;
        win_idx              = idx[PW-1:0];
        found                = 1'b1;
      end
    end
  end

  // Next pointer is one past the winner, so the winner becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i && found) begin
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/vc_allocator.sv
// Router-wide VC allocator: grants one free downstream VC per output port per cycle.
// Latency: grant and VC id are combinational (same cycle); free-pool updates land on the next edge.
// Backpressure: with no free VC on a port, requesters simply stay pending; releases re-enable grants a cycle later.
module vc_allocator
  import noc_params::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           request_i,
  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]           out_port_i,
  input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           idle_downstream_vc_i,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0]           vc_valid_o,
  output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o,
  output logic                                       error_o
);

  localparam int REQ_NUM = PORT_NUM * VC_NUM;
  localparam int PTR_W   = $clog2(REQ_NUM);

  logic [PORT_NUM-1:0][VC_NUM-1:0]  avail_q, avail_d;
  logic                             err_q, err_d;
  logic [PORT_NUM-1:0][REQ_NUM-1:0] port_req, arb_req, arb_grant;
  logic [PORT_NUM-1:0]              do_grant;
  logic [PORT_NUM-1:0][VC_SIZE-1:0] free_vc;
  logic [PORT_NUM-1:0][VC_NUM-1:0]  take_mask;
  logic [PORT_NUM-1:0][PTR_W-1:0]   rr_ptr_unused;

  // Route each input VC's request to the arbiter of the output port it asks for.
  always_comb begin
    port_req = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          port_req[o][p*VC_NUM+v] = request_i[p][v] && (out_port_i[p][v] == port_t'(o));
        end
      end
    end
  end

  // Lowest-index free VC per port; requests only reach the arbiter if one exists.
  always_comb begin
    free_vc  = '0;
    arb_req  = '0;
    do_grant = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int w = VC_NUM - 1; w >= 0; w--) begin
        if (avail_q[o][w]) begin
          free_vc[o] = VC_SIZE'(w);
        end
      end
      arb_req[o]  = (|avail_q[o]) ? port_req[o] : '0;
      do_grant[o] = |arb_req[o];
    end
  end

  generate
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
      round_robin_arbiter #(
        .N  (REQ_NUM),
        .PW (PTR_W)
      ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .requests_i (arb_req[o]),
        .update_i   (do_grant[o]),
        .grant_o    (arb_grant[o]),
        .ptr_o      (rr_ptr_unused[o])
      );
    end
  endgenerate

  // Fan the per-port grants back out to the requesting input VCs; silent during reset.
  always_comb begin
    vc_valid_o = '0;
    vc_new_o   = '0;
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int p = 0; p < PORT_NUM; p++) begin
          for (int v = 0; v < VC_NUM; v++) begin
            if (arb_grant[o][p*VC_NUM+v]) begin
              vc_valid_o[p][v] = 1'b1;
              vc_new_o[p][v]   = free_vc[o];
            end
          end
        end
      end
    end
  end

  // Free-pool update and protocol checks: grants claim a VC, releases return it,
  // releasing an already-free VC or requesting a non-existent port flags an error.
  always_comb begin
    take_mask = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (do_grant[o]) begin
        take_mask[o][free_vc[o]] = 1'b1;
      end
    end
    avail_d = (avail_q & ~take_mask) | idle_downstream_vc_i;
    err_d   = |(idle_downstream_vc_i & avail_q);
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (request_i[p][v] && (out_port_i[p][v] > EAST)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State registers: everything free and no error out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avail_q <= '1;
      err_q   <= 1'b0;
    end else begin
      avail_q <= avail_d;
      err_q   <= err_d;
    end
  end

  assign error_o = err_q;

endmodule

// File: tb/tb_vc_allocator.sv
// Self-checking bench for vc_allocator: directed scenarios plus random traffic
// checked against a free-list / round-robin reference model.
module tb_vc_allocator;
  import noc_params::*;

  localparam int NREQ = PORT_NUM * VC_NUM;

  logic clk = 1'b0;
  logic rst;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              idle;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]              vc_valid;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new;
  logic                                          error;

  always #5 clk = ~clk;

  vc_allocator dut (
    .clk                  (clk),
    .rst                  (rst),
    .request_i            (request),
    .out_port_i           (out_port),
    .idle_downstream_vc_i (idle),
    .vc_valid_o           (vc_valid),
    .vc_new_o             (vc_new),
    .error_o              (error)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit mavail[PORT_NUM][VC_NUM];
  int mptr[PORT_NUM];
  bit merr;
  logic [PORT_NUM-1:0][VC_NUM-1:0] exp_vld;
  int exp_new[PORT_NUM][VC_NUM];
  int g_win[PORT_NUM];
  int g_w[PORT_NUM];

  logic [PORT_NUM-1:0][VC_NUM-1:0] ev;
  int order[3] = '{0, 5, 8};
  int last_w;
  int obs;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void model_reset();
    for (int o = 0; o < PORT_NUM; o++) begin
      mptr[o] = 0;
      for (int v = 0; v < VC_NUM; v++) mavail[o][v] = 1'b1;
    end
    merr = 1'b0;
  endfunction

  // Who wins this cycle: per port, first matching requester going round from the pointer.
  function automatic void model_eval();
    int fw, i;
    exp_vld = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) exp_new[p][v] = 0;
    for (int o = 0; o < PORT_NUM; o++) begin
      g_win[o] = -1;
      g_w[o]   = -1;
      fw = -1;
      for (int w = 0; w < VC_NUM; w++) if (mavail[o][w] && fw < 0) fw = w;
      if (fw >= 0) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (mptr[o] + k) % NREQ;
          if (g_win[o] < 0 && request[i/VC_NUM][i%VC_NUM] &&
              int'(out_port[i/VC_NUM][i%VC_NUM]) == o) g_win[o] = i;
        end
        if (g_win[o] >= 0) begin
          g_w[o] = fw;
          exp_vld[g_win[o]/VC_NUM][g_win[o]%VC_NUM] = 1'b1;
          exp_new[g_win[o]/VC_NUM][g_win[o]%VC_NUM] = fw;
        end
      end
    end
  endfunction

  function automatic void model_update();
    bit e = 1'b0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        if (request[p][v] && int'(out_port[p][v]) > 4) e = 1'b1;
    for (int o = 0; o < PORT_NUM; o++)
      for (int v = 0; v < VC_NUM; v++)
        if (idle[o][v] && mavail[o][v]) e = 1'b1;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (g_win[o] >= 0) begin
        mavail[o][g_w[o]] = 1'b0;
        mptr[o] = (g_win[o] + 1) % NREQ;
      end
    end
    for (int o = 0; o < PORT_NUM; o++)
      for (int v = 0; v < VC_NUM; v++)
        if (idle[o][v]) mavail[o][v] = 1'b1;
    merr = e;
  endfunction

  task automatic clear_inputs();
    request = '0;
    idle    = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++) out_port[p][v] = LOCAL;
  endtask

  task automatic settle_check(input string tag);
    #1;
    model_eval();
    chk({tag, "/valid"}, 64'(vc_valid), 64'(exp_vld));
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_NUM; v++)
        if (exp_vld[p][v]) chk({tag, "/new"}, 64'(vc_new[p][v]), 64'(exp_new[p][v]));
    chk({tag, "/err"}, 64'(error), 64'(merr));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    request[1][0] = 1'b1;
    out_port[1][0] = EAST;
    #2;
    chk("reset_valid", 64'(vc_valid), 64'd0);
    chk("reset_new", 64'(vc_new), 64'd0);
    chk("reset_err", 64'(error), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First EAST allocation, then second VC, then exhaustion and release
    settle_check("east0");
    chk("east0_vld", 64'(vc_valid[1][0]), 64'd1);
    chk("east0_id", 64'(vc_new[1][0]), 64'd0);
    advance();
    request[1][0] = 1'b0;
    request[3][1] = 1'b1; out_port[3][1] = EAST;
    settle_check("east1");
    chk("east1_id", 64'(vc_new[3][1]), 64'd1);
    advance();
    request[3][1] = 1'b0;
    request[0][0] = 1'b1; out_port[0][0] = EAST;
    settle_check("east_full");
    chk("east_full_vld", 64'(vc_valid[0][0]), 64'd0);
    advance();
    idle[4][1] = 1'b1;
    settle_check("east_rel");
    chk("east_rel_nobypass", 64'(vc_valid[0][0]), 64'd0);
    advance();
    idle = '0;
    settle_check("east_after");
    chk("east_after_vld", 64'(vc_valid[0][0]), 64'd1);
    chk("east_after_id", 64'(vc_new[0][0]), 64'd1);
    advance();

    // Allocate four VCs, then asynchronous reset in the middle of a cycle
    clear_inputs();
    request[0][0] = 1'b1; out_port[0][0] = NORTH;
    request[1][0] = 1'b1; out_port[1][0] = SOUTH;
    request[2][0] = 1'b1; out_port[2][0] = WEST;
    request[3][0] = 1'b1; out_port[3][0] = LOCAL;
    settle_check("alloc4");
    advance();
    clear_inputs();
    request[4][0] = 1'b1; out_port[4][0] = NORTH;
    #1;
    chk("pre_rst_vld", 64'(vc_valid[4][0]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_vld", 64'(vc_valid), 64'd0);
    chk("rst_async_new", 64'(vc_new), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // Pointer must be back at 0: index 0 beats index 9
    request[4][1] = 1'b1; out_port[4][1] = EAST;
    request[0][0] = 1'b1; out_port[0][0] = EAST;
    settle_check("post_rst");
    ev = '0; ev[0][0] = 1'b1;
    chk("post_rst_winner", 64'(vc_valid), 64'(ev));
    chk("post_rst_id", 64'(vc_new[0][0]), 64'd0);
    advance();
    clear_inputs();

    // Independent ports in the same cycle
    request[0][1] = 1'b1; out_port[0][1] = NORTH;
    request[2][0] = 1'b1; out_port[2][0] = SOUTH;
    settle_check("ns_same");
    ev = '0; ev[0][1] = 1'b1; ev[2][0] = 1'b1;
    chk("ns_both_vld", 64'(vc_valid), 64'(ev));
    chk("ns_north_id", 64'(vc_new[0][1]), 64'd0);
    chk("ns_south_id", 64'(vc_new[2][0]), 64'd0);
    advance();
    clear_inputs();
    request[0][0] = 1'b1; out_port[0][0] = NORTH;
    request[4][1] = 1'b1; out_port[4][1] = NORTH;
    request[2][0] = 1'b1; out_port[2][0] = SOUTH;
    request[1][0] = 1'b1; out_port[1][0] = SOUTH;
    settle_check("ns_ptrs");
    ev = '0; ev[4][1] = 1'b1; ev[1][0] = 1'b1;
    chk("ns_ptr_winners", 64'(vc_valid), 64'(ev));
    advance();
    clear_inputs();

    // Releasing a free VC raises error for exactly one cycle
    idle[0][0] = 1'b1;
    settle_check("rel_free");
    advance();
    idle = '0;
    settle_check("err_next");
    chk("err_set", 64'(error), 64'd1);
    advance();
    settle_check("err_clear");
    chk("err_cleared", 64'(error), 64'd0);
    advance();

    // Request to a non-existent port
    request[2][1] = 1'b1; out_port[2][1] = port_t'(6);
    settle_check("bad_port");
    advance();
    clear_inputs();
    settle_check("bad_port_err");
    chk("bad_port_flag", 64'(error), 64'd1);
    advance();

    // Round-robin fairness on WEST with the granted VC released each following cycle
    request[0][0] = 1'b1; out_port[0][0] = WEST;
    request[2][1] = 1'b1; out_port[2][1] = WEST;
    request[4][0] = 1'b1; out_port[4][0] = WEST;
    last_w = -1;
    for (int k = 0; k < 6; k++) begin
      idle = '0;
      if (last_w >= 0) idle[3][last_w] = 1'b1;
      settle_check("rr_west");
      obs = -1;
      for (int p = 0; p < PORT_NUM; p++)
        for (int v = 0; v < VC_NUM; v++)
          if (vc_valid[p][v]) obs = p * VC_NUM + v;
      chk("rr_order", 64'(obs), 64'(order[k % 3]));
      last_w = g_w[3];
      advance();
    end
    clear_inputs();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        for (int v = 0; v < VC_NUM; v++) begin
          request[p][v] = ($urandom_range(0, 99) < 40);
          if ($urandom_range(0, 49) == 0)
            out_port[p][v] = port_t'($urandom_range(5, 7));
          else
            out_port[p][v] = port_t'($urandom_range(0, 4));
        end
      end
      for (int o = 0; o < PORT_NUM; o++)
        for (int v = 0; v < VC_NUM; v++)
          idle[o][v] = !mavail[o][v] ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 39) == 0);
      settle_check("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
